bru_resolve: RTL and testbench
==============================

# bru_resolve

Branch resolution stage sitting directly downstream of the 64-bit comparator in the execute path. It consumes the comparator's less-than and equality flags, decides the outcome of conditional branches, JAL and JALR, computes the target and link value, and registers them. On a taken control transfer it issues a one-cycle redirect to fetch, then holds a flush window that squashes younger instructions.

## Interface
- `XLEN`, 64: datapath width.
- `FLUSH_CYCLES`, 2: cycles the flush window is held after a redirect; legal range 1–15.
- `clock`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: instruction presented.
- `in_ready`  out  1: stage can accept.
- `is_branch`, `is_jal`, `is_jalr`  in  1 each: one-hot or all zero; all zero means pass-through, no control transfer.
- `funct3`  in  3: branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- `pc`, `imm`, `rs1`  in  XLEN: operands for target computation.
- `cmp_lt`  in  1: comparator result bit 0.
- `cmp_eq`  in  1: comparator equality flag.
- `cmp_u`  out  1: unsigned select to the comparator, equal to `funct3[1]`, combinational.
- `out_valid`  out  1: registered result valid.
- `out_ready`  in  1: downstream accepts.
- `link_we`  out  1: link write required (JAL/JALR).
- `link_data`  out  XLEN: pc+4.
- `redirect_valid`  out  1: one-cycle redirect pulse.
- `redirect_pc`  out  XLEN: redirect target.
- `flush`  out  1: squash younger instructions in upstream stages.
- `exc_misalign`  out  1: target misaligned (present only under `BRU_MISALIGN_EN`).

## Operation
- Accept when `in_valid && in_ready`; `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
- Taken:
  - BEQ: `cmp_eq`
  - BNE: `!cmp_eq`
  - BLT/BLTU: `cmp_lt`
  - BGE/BGEU: `!cmp_lt`
  - Undefined funct3 (010, 011): not taken.
  - JAL/JALR: always taken.
- Target:
  - Branch/JAL: `pc+imm`.
  - JALR: `(rs1+imm) & ~1`.
  - All sums are modulo 2^XLEN; wrap-around is silent.
- `link_data = pc+4`, registered for every accepted instruction; `link_we = is_jal|is_jalr`.
- States:
  - IDLE → FLUSH on accepting a taken transfer. Load counter with FLUSH_CYCLES.
  - FLUSH: counter decrements each cycle and `flush=1`. When the counter reaches 1, return to IDLE. `in_valid` is ignored throughout FLUSH.
- Output register holds while `out_valid && !out_ready`.
- The redirect pulse is independent of `out_ready`; it is never delayed by a downstream stall.

## Timing
- Reset values: `out_valid=0`, `link_we=0`, `link_data=0`, `redirect_valid=0`, `redirect_pc=0`, `flush=0`, `exc_misalign=0`, state IDLE, counter 0.
- Latency 1: an instruction accepted in cycle N has `out_valid`, `redirect_valid` and `redirect_pc` asserted in N+1.
- `flush` is high in cycles N+1 through N+FLUSH_CYCLES. `in_ready` is low for the same cycles.
- Back-to-back not-taken instructions are accepted every cycle when `out_ready=1`.
- Reset asserted mid-FLUSH or mid-stall: returns to reset values on the next edge. A pending redirect is dropped.

## Configuration
- `BRU_MISALIGN_EN` defined:
  - A taken target with `target[1:0]!=0` sets `exc_misalign=1` alongside `out_valid`.
  - Redirect and flush are suppressed for that instruction.
  - `link_we` is forced 0.
- `BRU_MISALIGN_EN` undefined:
  - The port is absent and no alignment check is made.
  - JALR bit 0 is still cleared.

## Structure
- Shared package: funct3 branch encodings, `REG_BUS` width define, state encoding (IDLE, FLUSH).
- One sub-module, `bru_cond`: combinational taken decode from funct3, `cmp_lt` and `cmp_eq`.
- Adders, state machine, counter and output registers live in `bru_resolve`.

## Test plan
- BEQ, pc=0x1000, imm=0x20, `cmp_eq=1`:
  - Cycle after accept: `redirect_valid=1`, `redirect_pc=0x1020`.
  - `flush` high 2 cycles.
  - `in_ready` low 2 cycles.
- BLTU, `cmp_lt=0`: not taken.
  - `cmp_u=1`, no redirect, `flush=0`.
  - Next instruction accepted in the following cycle.
- JALR, rs1=0x2001, imm=0x4, pc=0x3000:
  - `redirect_pc=0x2004`.
  - `link_we=1`, `link_data=0x3004`.
- JAL with `out_ready=0` for 3 cycles:
  - Redirect pulses once, one cycle after accept.
  - Output holds stable until `out_ready=1`.
- Reset asserted in the first FLUSH cycle:
  - Next cycle all outputs are 0 and `in_ready=1`.
- `BRU_MISALIGN_EN`, BEQ taken with target 0x1002:
  - `exc_misalign=1`, `redirect_valid=0`, `flush=0`.

Source files
------------

// File: rtl/bru_resolve_pkg.sv
// Shared definitions for the branch resolution stage: bus width,
// RISC-V branch funct3 encodings and the resolve FSM state encoding.
package bru_resolve_pkg;

  localparam int REG_BUS = 64;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

endpackage

// File: rtl/bru_resolve_if.sv
// Bundle of handshake, operand and result signals around bru_resolve.
// master = upstream/downstream environment, slave = the resolve stage.
interface bru_resolve_if #(
  parameter int XLEN = 64
);

  logic            in_valid;
  logic            in_ready;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            cmp_lt;
  logic            cmp_eq;
  logic            cmp_u;
  logic            out_valid;
  logic            out_ready;
  logic            link_we;
  logic [XLEN-1:0] link_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;

  modport master (
    output in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, rs1,
    output cmp_lt, cmp_eq, out_ready,
    input  in_ready, cmp_u, out_valid, link_we, link_data,
    input  redirect_valid, redirect_pc, flush
  );

  modport slave (
    input  in_valid, is_branch, is_jal, is_jalr, funct3, pc, imm, rs1,
    input  cmp_lt, cmp_eq, out_ready,
    output in_ready, cmp_u, out_valid, link_we, link_data,
    output redirect_valid, redirect_pc, flush
  );

endinterface

// File: rtl/bru_resolve_cond.sv
// bru_cond: combinational branch-taken decode from funct3 and the
// comparator flags; undefined encodings resolve as not taken.
module bru_cond
  import bru_resolve_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       cmp_lt,
  input  logic       cmp_eq,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = cmp_eq;
      F3_BNE:           taken = !cmp_eq;
      F3_BLT, F3_BLTU:  taken = cmp_lt;
      F3_BGE, F3_BGEU:  taken = !cmp_lt;
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/bru_resolve.sv
// Branch resolution stage: decides branch/JAL/JALR outcome, registers target
// and link value, pulses redirect and holds a flush window. Optional: BRU_MISALIGN_EN.
module bru_resolve
  import bru_resolve_pkg::*;
#(
  parameter int XLEN         = REG_BUS,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  bru_resolve_if.slave bus
`ifdef BRU_MISALIGN_EN
  ,
  output logic         exc_misalign
`endif
);

  bru_state_e      state;
  bru_state_e      state_next;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic            cond_taken;
  logic            taken;
  logic            misalign;
  logic            redirect_go;
  logic            accept;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link_sum;

  bru_cond u_cond (
    .funct3 (bus.funct3),
    .cmp_lt (bus.cmp_lt),
    .cmp_eq (bus.cmp_eq),
    .taken  (cond_taken)
  );

  assign bus.cmp_u    = bus.funct3[1];
  assign bus.in_ready = (state == ST_IDLE) && (!bus.out_valid || bus.out_ready);
  assign bus.flush    = (state == ST_FLUSH);
  assign accept       = bus.in_valid && bus.in_ready;

  assign taken    = (bus.is_branch && cond_taken) || bus.is_jal || bus.is_jalr;
  assign target   = bus.is_jalr ? ((bus.rs1 + bus.imm) & {{(XLEN-1){1'b1}}, 1'b0})
                                : (bus.pc + bus.imm);
  assign link_sum = bus.pc + XLEN'(4);

  // A misaligned taken target becomes an exception instead of a redirect.
`ifdef BRU_MISALIGN_EN
  assign misalign = taken && (target[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign redirect_go = taken && !misalign;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept && redirect_go) begin
          state_next = ST_FLUSH;
          cnt_next   = 4'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (cnt <= 4'd1) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Redirect defaults low each cycle so it can only ever pulse for one cycle,
  // regardless of whether the result register is stalled by downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.out_valid      <= 1'b0;
      bus.link_we        <= 1'b0;
      bus.link_data      <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
`ifdef BRU_MISALIGN_EN
      exc_misalign       <= 1'b0;
`endif
    end else begin
      bus.redirect_valid <= 1'b0;
      if (accept) begin
        bus.out_valid      <= 1'b1;
        bus.link_we        <= (bus.is_jal || bus.is_jalr) && !misalign;
        bus.link_data      <= link_sum;
        bus.redirect_valid <= redirect_go;
        if (redirect_go) begin
          bus.redirect_pc <= target;
        end
`ifdef BRU_MISALIGN_EN
        exc_misalign       <= misalign;
`endif
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
`ifdef BRU_MISALIGN_EN
        exc_misalign  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bru_resolve.sv
// Directed self-checking bench for bru_resolve with hand-computed vectors.
module tb_bru_resolve;
  import bru_resolve_pkg::*;

  localparam int XLEN = 64;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  bru_resolve_if #(.XLEN(XLEN)) bus ();

`ifdef BRU_MISALIGN_EN
  logic exc_misalign;
`endif

  bru_resolve #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave)
`ifdef BRU_MISALIGN_EN
    ,
    .exc_misalign (exc_misalign)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(
    input logic            valid,
    input logic            br,
    input logic            jal,
    input logic            jalr,
    input logic [2:0]      f3,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] rs1,
    input logic            lt,
    input logic            eq
  );
    bus.in_valid  = valid;
    bus.is_branch = br;
    bus.is_jal    = jal;
    bus.is_jalr   = jalr;
    bus.funct3    = f3;
    bus.pc        = pc;
    bus.imm       = imm;
    bus.rs1       = rs1;
    bus.cmp_lt    = lt;
    bus.cmp_eq    = eq;
  endtask

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.out_ready = 1'b1;
    idleInputs();
    tick();
    tick();

    // Reset state
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_link_we", 64'(bus.link_we), 64'd0);
    checkOutput("rst_link_data", bus.link_data, 64'd0);
    checkOutput("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("rst_redirect_pc", bus.redirect_pc, 64'd0);
    checkOutput("rst_flush", 64'(bus.flush), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef BRU_MISALIGN_EN
    checkOutput("rst_exc_misalign", 64'(exc_misalign), 64'd0);
`endif
    reset = 1'b0;
    tick();

    // BEQ taken: pc 0x1000 + 0x20
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 64'h1000, 64'h20, '0, 1'b0, 1'b1);
    #1;
    checkOutput("beq_in_ready_pre", 64'(bus.in_ready), 64'd1);
    checkOutput("beq_cmp_u", 64'(bus.cmp_u), 64'd0);
    tick();
    idleInputs();
    checkOutput("beq_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("beq_redirect_valid", 64'(bus.redirect_valid), 64'd1);
    checkOutput("beq_redirect_pc", bus.redirect_pc, 64'h1020);
    checkOutput("beq_link_we", 64'(bus.link_we), 64'd0);
    checkOutput("beq_link_data", bus.link_data, 64'h1004);
    checkOutput("beq_flush_c1", 64'(bus.flush), 64'd1);
    checkOutput("beq_in_ready_c1", 64'(bus.in_ready), 64'd0);
    tick();
    checkOutput("beq_redirect_c2", 64'(bus.redirect_valid), 64'd0);
    checkOutput("beq_flush_c2", 64'(bus.flush), 64'd1);
    checkOutput("beq_in_ready_c2", 64'(bus.in_ready), 64'd0);
    tick();
    checkOutput("beq_flush_c3", 64'(bus.flush), 64'd0);
    checkOutput("beq_in_ready_c3", 64'(bus.in_ready), 64'd1);
    checkOutput("beq_out_valid_c3", 64'(bus.out_valid), 64'd0);

    // Back-to-back not-taken: BLTU lt=0, BNE eq=1, undefined funct3 010
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 64'h1200, 64'h40, '0, 1'b0, 1'b0);
    #1;
    checkOutput("bltu_cmp_u", 64'(bus.cmp_u), 64'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 64'h1204, 64'h40, '0, 1'b0, 1'b1);
    checkOutput("bltu_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("bltu_redirect", 64'(bus.redirect_valid), 64'd0);
    checkOutput("bltu_flush", 64'(bus.flush), 64'd0);
    checkOutput("bltu_link_data", bus.link_data, 64'h1204);
    checkOutput("bltu_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 64'h1208, 64'h40, '0, 1'b1, 1'b1);
    checkOutput("bne_redirect", 64'(bus.redirect_valid), 64'd0);
    checkOutput("bne_link_data", bus.link_data, 64'h1208);
    checkOutput("bne_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    idleInputs();
    checkOutput("f3_010_redirect", 64'(bus.redirect_valid), 64'd0);
    checkOutput("f3_010_flush", 64'(bus.flush), 64'd0);
    checkOutput("f3_010_link_data", bus.link_data, 64'h120C);

    // BGE taken with negative offset: 0x6000 - 0x10
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 64'h6000, 64'hFFFF_FFFF_FFFF_FFF0, '0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("bge_redirect_valid", 64'(bus.redirect_valid), 64'd1);
    checkOutput("bge_redirect_pc", bus.redirect_pc, 64'h5FF0);
    tick();
    tick();

    // JALR: (0x2001 + 4) & ~1
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 64'h3000, 64'h4, 64'h2001, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("jalr_redirect_valid", 64'(bus.redirect_valid), 64'd1);
    checkOutput("jalr_redirect_pc", bus.redirect_pc, 64'h2004);
    checkOutput("jalr_link_we", 64'(bus.link_we), 64'd1);
    checkOutput("jalr_link_data", bus.link_data, 64'h3004);
    tick();
    tick();

    // JAL with wrap-around of target
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, '0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("jal_wrap_redirect_pc", bus.redirect_pc, 64'h10);
    checkOutput("jal_wrap_link_data", bus.link_data, 64'hFFFF_FFFF_FFFF_FFF4);
    tick();
    tick();

    // JAL with downstream stalled for 3 cycles
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 64'h4000, 64'h100, '0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("jal_st_redirect_c1", 64'(bus.redirect_valid), 64'd1);
    checkOutput("jal_st_redirect_pc", bus.redirect_pc, 64'h4100);
    checkOutput("jal_st_out_valid_c1", 64'(bus.out_valid), 64'd1);
    checkOutput("jal_st_link_we", 64'(bus.link_we), 64'd1);
    checkOutput("jal_st_link_data_c1", bus.link_data, 64'h4004);
    tick();
    checkOutput("jal_st_redirect_c2", 64'(bus.redirect_valid), 64'd0);
    checkOutput("jal_st_out_valid_c2", 64'(bus.out_valid), 64'd1);
    checkOutput("jal_st_link_data_c2", bus.link_data, 64'h4004);
    checkOutput("jal_st_flush_c2", 64'(bus.flush), 64'd1);
    tick();
    checkOutput("jal_st_redirect_c3", 64'(bus.redirect_valid), 64'd0);
    checkOutput("jal_st_flush_c3", 64'(bus.flush), 64'd0);
    checkOutput("jal_st_in_ready_c3", 64'(bus.in_ready), 64'd0);
    checkOutput("jal_st_out_valid_c3", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("jal_st_in_ready_rel", 64'(bus.in_ready), 64'd1);
    tick();
    checkOutput("jal_st_out_valid_done", 64'(bus.out_valid), 64'd0);

    // Reset in the first FLUSH cycle drops everything
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 64'h5000, 64'h8, '0, 1'b0, 1'b1);
    tick();
    idleInputs();
    checkOutput("rstf_flush_pre", 64'(bus.flush), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstf_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rstf_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    checkOutput("rstf_redirect_pc", bus.redirect_pc, 64'd0);
    checkOutput("rstf_link_data", bus.link_data, 64'd0);
    checkOutput("rstf_link_we", 64'(bus.link_we), 64'd0);
    checkOutput("rstf_flush", 64'(bus.flush), 64'd0);
    checkOutput("rstf_in_ready", 64'(bus.in_ready), 64'd1);

`ifdef BRU_MISALIGN_EN
    // Misaligned taken targets raise an exception instead of redirecting
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 64'h1000, 64'h2, '0, 1'b0, 1'b1);
    tick();
    idleInputs();
    checkOutput("mis_beq_exc", 64'(exc_misalign), 64'd1);
    checkOutput("mis_beq_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("mis_beq_redirect", 64'(bus.redirect_valid), 64'd0);
    checkOutput("mis_beq_flush", 64'(bus.flush), 64'd0);
    checkOutput("mis_beq_in_ready", 64'(bus.in_ready), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 64'h1000, 64'h6, '0, 1'b0, 1'b0);
    tick();
    idleInputs();
    checkOutput("mis_jal_exc", 64'(exc_misalign), 64'd1);
    checkOutput("mis_jal_link_we", 64'(bus.link_we), 64'd0);
    checkOutput("mis_jal_redirect", 64'(bus.redirect_valid), 64'd0);
    tick();
    checkOutput("mis_exc_clear", 64'(exc_misalign), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
